// File: rtl/mod_segment_swapchain_if.sv
// ---------------------------------------------------------------------------
// mod_segment_swapchain_if
// Handshake/bus bundle between the register bank + sampler and the
// modulation segment swap chain.
//   UPDATE_SETTINGS : one-cycle pulse, REQ_RD_SEGMENT/REP_0/REP_1 valid
//   REQ_RD_SEGMENT  : requested read segment
//   REP_0 / REP_1   : repetitions per segment, all-ones = infinite
//   IDX / IDX_ADV   : sampler index and its one-cycle advance strobe
//   SEGMENT         : active read segment
//   STOP            : finite playback exhausted, sampler must hold
//   SWAP_PENDING    : finite request waiting for the cycle boundary
// master = register bank / sampler side, slave = swap chain.
// ---------------------------------------------------------------------------
interface mod_segment_swapchain_if #(
   parameter int unsigned IDX_WIDTH = 15,
   parameter int unsigned REP_WIDTH = 32
);
   logic                 UPDATE_SETTINGS;
   logic                 REQ_RD_SEGMENT;
   logic [REP_WIDTH-1:0] REP_0;
   logic [REP_WIDTH-1:0] REP_1;
   logic [IDX_WIDTH-1:0] IDX;
   logic                 IDX_ADV;
   logic                 SEGMENT;
   logic                 STOP;
   logic                 SWAP_PENDING;

   modport master (
      output UPDATE_SETTINGS, REQ_RD_SEGMENT, REP_0, REP_1, IDX, IDX_ADV,
      input  SEGMENT, STOP, SWAP_PENDING
   );

   modport slave (
      input  UPDATE_SETTINGS, REQ_RD_SEGMENT, REP_0, REP_1, IDX, IDX_ADV,
      output SEGMENT, STOP, SWAP_PENDING
   );
endinterface

// File: rtl/mod_segment_swapchain.sv
// ---------------------------------------------------------------------------
// mod_segment_swapchain
// Selects which modulation segment (0/1) the sampler reads.
//   Infinite request (REP of requested segment all-ones): swap next cycle.
//   Finite request: wait for the next index wrap (IDX_ADV && IDX==0), swap,
//   play rep_sel+1 loops, then raise STOP and hold until new settings.
// Ports:
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : mod_segment_swapchain_if.slave (settings, index strobe,
//                SEGMENT/STOP/SWAP_PENDING outputs, all registered)
// Optional macro MOD_SWAPCHAIN_DEBUG_EN adds registered outputs:
//   LOOP_CNT [REP_WIDTH-1:0] : loop counter (0 outside FINITE_LOOP/DONE)
//   STATE    [1:0]           : INFINITE=0, WAIT_BOUNDARY=1, FINITE_LOOP=2, DONE=3
// ---------------------------------------------------------------------------
module mod_segment_swapchain #(
   parameter int unsigned IDX_WIDTH = 15,
   parameter int unsigned REP_WIDTH = 32
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   mod_segment_swapchain_if.slave bus
`ifdef MOD_SWAPCHAIN_DEBUG_EN
   ,
   output logic [REP_WIDTH-1:0] LOOP_CNT,
   output logic [1:0]           STATE
`endif
);

   typedef enum logic [1:0] {
      ST_INFINITE      = 2'd0,
      ST_WAIT_BOUNDARY = 2'd1,
      ST_FINITE_LOOP   = 2'd2,
      ST_DONE          = 2'd3
   } state_t;

   state_t               state_q, state_d;
   logic                 seg_q, seg_d;
   logic                 stop_q, stop_d;
   logic                 pend_q, pend_d;
   logic                 req_seg_q, req_seg_d;
   logic [REP_WIDTH-1:0] rep_sel_q, rep_sel_d;
   logic [REP_WIDTH-1:0] cnt_q, cnt_d;

   logic                 wrap;
   logic [REP_WIDTH-1:0] rep_req;

   assign wrap    = bus.IDX_ADV && (bus.IDX == '0);
   assign rep_req = bus.REQ_RD_SEGMENT ? bus.REP_1 : bus.REP_0;

   always_comb begin
      state_d   = state_q;
      seg_d     = seg_q;
      stop_d    = stop_q;
      pend_d    = pend_q;
      req_seg_d = req_seg_q;
      rep_sel_d = rep_sel_q;
      cnt_d     = cnt_q;

      // New settings take priority over a same-cycle wrap, so the wrap is
      // never credited to the request or loop count being replaced.
      if (bus.UPDATE_SETTINGS) begin
         stop_d = 1'b0;
         cnt_d  = '0;
         if (rep_req == '1) begin
            seg_d   = bus.REQ_RD_SEGMENT;
            pend_d  = 1'b0;
            state_d = ST_INFINITE;
         end else begin
            req_seg_d = bus.REQ_RD_SEGMENT;
            rep_sel_d = rep_req;
            pend_d    = 1'b1;
            state_d   = ST_WAIT_BOUNDARY;
         end
      end else begin
         unique case (state_q)
            ST_WAIT_BOUNDARY: begin
               // The swapping wrap opens loop 0.
               if (wrap) begin
                  seg_d   = req_seg_q;
                  cnt_d   = '0;
                  pend_d  = 1'b0;
                  state_d = ST_FINITE_LOOP;
               end
            end
            ST_FINITE_LOOP: begin
               if (wrap) begin
                  if (cnt_q == rep_sel_q) begin
                     stop_d  = 1'b1;
                     state_d = ST_DONE;
                  end else begin
                     cnt_d = cnt_q + REP_WIDTH'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= ST_INFINITE;
         seg_q     <= 1'b0;
         stop_q    <= 1'b0;
         pend_q    <= 1'b0;
         req_seg_q <= 1'b0;
         rep_sel_q <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         seg_q     <= seg_d;
         stop_q    <= stop_d;
         pend_q    <= pend_d;
         req_seg_q <= req_seg_d;
         rep_sel_q <= rep_sel_d;
         cnt_q     <= cnt_d;
      end
   end

   assign bus.SEGMENT      = seg_q;
   assign bus.STOP         = stop_q;
   assign bus.SWAP_PENDING = pend_q;

`ifdef MOD_SWAPCHAIN_DEBUG_EN
   assign LOOP_CNT = cnt_q;
   assign STATE    = state_q;
`endif

endmodule

// File: tb/tb_mod_segment_swapchain.sv
// ---------------------------------------------------------------------------
// tb_mod_segment_swapchain
// Directed bench for mod_segment_swapchain: reset, infinite swap, finite
// swap with loop counting, zero-repeat, update/wrap collision, async reset.
// ---------------------------------------------------------------------------
module tb_mod_segment_swapchain;

   logic clk;
   logic rst_n;
   int   passed;
   int   total;

   mod_segment_swapchain_if #(.IDX_WIDTH(15), .REP_WIDTH(32)) bus_if ();

`ifdef MOD_SWAPCHAIN_DEBUG_EN
   logic [31:0] loop_cnt;
   logic [1:0]  state;
`endif

   mod_segment_swapchain #(.IDX_WIDTH(15), .REP_WIDTH(32)) dut (
      .CLK   (clk),
      .RST_N (rst_n),
      .bus   (bus_if.slave)
`ifdef MOD_SWAPCHAIN_DEBUG_EN
      ,
      .LOOP_CNT (loop_cnt),
      .STATE    (state)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic check_out(input string tag, input logic seg, input logic stop, input logic pend);
      check({tag, ".SEGMENT"},      {31'd0, bus_if.SEGMENT},      {31'd0, seg});
      check({tag, ".STOP"},         {31'd0, bus_if.STOP},         {31'd0, stop});
      check({tag, ".SWAP_PENDING"}, {31'd0, bus_if.SWAP_PENDING}, {31'd0, pend});
   endtask

   // One clock with the given index strobe; settings pulse is dropped after.
   task automatic step(input logic adv, input int idx);
      bus_if.IDX_ADV = adv;
      bus_if.IDX     = idx[14:0];
      @(posedge clk);
      #1;
      bus_if.IDX_ADV         = 1'b0;
      bus_if.UPDATE_SETTINGS = 1'b0;
   endtask

   // Index 1..9 then the wrapping 0 strobe.
   task automatic run_cycle();
      for (int i = 1; i <= 9; i++) step(1'b1, i);
      step(1'b1, 0);
   endtask

   task automatic update(input logic req, input logic [31:0] rep0, input logic [31:0] rep1);
      bus_if.UPDATE_SETTINGS = 1'b1;
      bus_if.REQ_RD_SEGMENT  = req;
      bus_if.REP_0           = rep0;
      bus_if.REP_1           = rep1;
   endtask

   initial begin
      passed = 0;
      total  = 0;
      rst_n  = 1'b0;
      bus_if.UPDATE_SETTINGS = 1'b0;
      bus_if.REQ_RD_SEGMENT  = 1'b0;
      bus_if.REP_0           = '0;
      bus_if.REP_1           = '0;
      bus_if.IDX             = '0;
      bus_if.IDX_ADV         = 1'b0;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      check_out("reset", 1'b0, 1'b0, 1'b0);
      rst_n = 1'b1;
      step(1'b0, 0);
      check_out("post_reset", 1'b0, 1'b0, 1'b0);

      // 100 wraps in INFINITE change nothing
      for (int i = 0; i < 100; i++) step(1'b1, 0);
      check_out("idle_wraps", 1'b0, 1'b0, 1'b0);

      // Infinite swap to segment 1 mid-cycle, latency 1
      update(1'b1, 32'd0, 32'hFFFF_FFFF);
      bus_if.IDX = 15'd7;
      #1;
      check("inf_no_comb_path", {31'd0, bus_if.SEGMENT}, 32'd0);
      step(1'b0, 7);
      check_out("inf_swap", 1'b1, 1'b0, 1'b0);

      // Finite request: segment 0, REP_0=2
      update(1'b0, 32'd2, 32'hFFFF_FFFF);
      step(1'b0, 7);
      check_out("fin_req", 1'b1, 1'b0, 1'b1);
      for (int i = 8; i <= 9; i++) step(1'b1, i);
      check_out("fin_wait", 1'b1, 1'b0, 1'b1);
      step(1'b1, 0);
      check_out("fin_swap", 1'b0, 1'b0, 1'b0);
      run_cycle();
      check_out("fin_wrap1", 1'b0, 1'b0, 1'b0);
      run_cycle();
      check_out("fin_wrap2", 1'b0, 1'b0, 1'b0);
      run_cycle();
      check_out("fin_wrap3_stop", 1'b0, 1'b1, 1'b0);
      run_cycle();
      run_cycle();
      check_out("fin_done_hold", 1'b0, 1'b1, 1'b0);

      // REP_0=0 on already-active segment 0: waits, swaps, stops next wrap
      update(1'b0, 32'd0, 32'hFFFF_FFFF);
      step(1'b1, 4);
      check_out("rep0_req", 1'b0, 1'b0, 1'b1);
      run_cycle();
      check_out("rep0_swap", 1'b0, 1'b0, 1'b0);
      run_cycle();
      check_out("rep0_stop", 1'b0, 1'b1, 1'b0);

      // Update colliding with a wrap while waiting for segment 0
      update(1'b1, 32'd0, 32'hFFFF_FFFF);
      step(1'b0, 3);
      check_out("coll_inf1", 1'b1, 1'b0, 1'b0);
      update(1'b0, 32'd3, 32'hFFFF_FFFF);
      step(1'b1, 4);
      check_out("coll_wait0", 1'b1, 1'b0, 1'b1);
      for (int i = 5; i <= 9; i++) step(1'b1, i);
      update(1'b1, 32'd3, 32'd5);
      step(1'b1, 0);
      check_out("coll_same_cycle", 1'b1, 1'b0, 1'b1);
      run_cycle();
      check_out("coll_swap1", 1'b1, 1'b0, 1'b0);
      run_cycle();
      check_out("coll_loop1", 1'b1, 1'b0, 1'b0);
`ifdef MOD_SWAPCHAIN_DEBUG_EN
      check("dbg_state_finite", {30'd0, state}, 32'd2);
      check("dbg_loop_cnt1", loop_cnt, 32'd1);
`endif

      // Asynchronous reset during loop 1
      step(1'b1, 3);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_reset", 1'b0, 1'b0, 1'b0);
`ifdef MOD_SWAPCHAIN_DEBUG_EN
      check("dbg_state_reset", {30'd0, state}, 32'd0);
      check("dbg_loop_cnt_reset", loop_cnt, 32'd0);
`endif
      #2;
      rst_n = 1'b1;
      run_cycle();
      run_cycle();
      check_out("after_reset_no_pending", 1'b0, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mod_segment_swapchain.md
Name: mod_segment_swapchain

Overview:
- Sits between the controller register bank and the modulation sampler/memory read path.
- Decides which of the two modulation segments (0/1) is read.
- Supports two swap modes:
  - Infinite: immediate swap.
  - Finite: swap on a cycle boundary, then play the new segment for a fixed number of loops and stop.
- Consumes the latched MOD_REQ_RD_SEGMENT and MOD_REP_x settings. Consumes the sampler's index-advance strobe.

Parameters:
- IDX_WIDTH, 15, width of modulation sample index.
- REP_WIDTH, 32, width of repetition count (two 16-bit register words).

Ports:
- CLK  in  1  system clock
- RST_N  in  1  asynchronous active-low reset
- UPDATE_SETTINGS  in  1  one-cycle pulse: REQ_RD_SEGMENT/REP_0/REP_1 valid
- REQ_RD_SEGMENT  in  1  requested read segment
- REP_0  in  REP_WIDTH  repetitions for segment 0; all-ones = infinite
- REP_1  in  REP_WIDTH  repetitions for segment 1; all-ones = infinite
- IDX  in  IDX_WIDTH  current sample index from sampler
- IDX_ADV  in  1  one-cycle pulse: IDX changed this cycle
- SEGMENT  out  1  active read segment
- STOP  out  1  finite playback exhausted; sampler must hold
- SWAP_PENDING  out  1  finite request waiting for boundary

Behaviour:
- Reset (async, RST_N=0):
  - SEGMENT=0, STOP=0, SWAP_PENDING=0.
  - State=INFINITE, loop counter=0.
  - Deassertion mid-operation discards any pending request.
- Boundary: wrap = IDX_ADV && IDX==0. This is evaluated only in the cycle of the strobe.
- rep_sel: REP of the requested segment, latched together with the request on UPDATE_SETTINGS.
- States: INFINITE, WAIT_BOUNDARY, FINITE_LOOP, DONE.
- On UPDATE_SETTINGS in any state:
  - If rep_sel is all-ones:
    - SEGMENT<=REQ_RD_SEGMENT next cycle (latency 1), STOP<=0, SWAP_PENDING<=0.
    - State->INFINITE.
  - Otherwise:
    - Latch req_seg and rep_sel; SWAP_PENDING<=1; STOP<=0.
    - State->WAIT_BOUNDARY.
    - SEGMENT is unchanged.
- WAIT_BOUNDARY:
  - On wrap: SEGMENT<=req_seg, loop counter<=0, SWAP_PENDING<=0, state->FINITE_LOOP.
  - The same wrap is the start of loop 0, not the end of one.
- FINITE_LOOP:
  - On each subsequent wrap: if loop counter==rep_sel, STOP<=1 and state->DONE; else counter increments.
  - Total loops played = rep_sel+1. With rep_sel=0, STOP asserts on the first wrap after the swap.
- DONE:
  - STOP held at 1 and SEGMENT held.
  - IDX_ADV is ignored.
  - Leaves only on UPDATE_SETTINGS.
- INFINITE: wraps are ignored; no counting.
- Simultaneous UPDATE_SETTINGS and wrap in one cycle:
  - UPDATE_SETTINGS wins.
  - The wrap is not applied to the old pending request or loop count.
- Request for the segment already active is treated identically: a finite request still waits for the boundary and restarts counting.
- The loop counter is REP_WIDTH bits and never wraps, because DONE is reached at equality first.
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: MOD_SWAPCHAIN_DEBUG_EN.
- Defined: adds output port LOOP_CNT [REP_WIDTH-1:0] (current loop counter, 0 outside FINITE_LOOP/DONE) and output STATE [1:0] (INFINITE=0, WAIT_BOUNDARY=1, FINITE_LOOP=2, DONE=3), both registered.
- Undefined: ports absent; core behaviour identical.

Test Plan:
- Reset release, no stimulus -> SEGMENT=0, STOP=0, SWAP_PENDING=0; 100 IDX_ADV wraps change nothing.
- UPDATE_SETTINGS REQ=1, REP_1=0xFFFFFFFF mid-cycle (IDX=7) -> SEGMENT=1 exactly one cycle later; STOP stays 0.
- From segment 1 infinite, UPDATE_SETTINGS REQ=0, REP_0=2; drive IDX 0..9 repeatedly -> SWAP_PENDING=1 until the next IDX=0 strobe, then SEGMENT=0. STOP rises on the 3rd following wrap (3 loops total) and stays 1 for later strobes.
- REP_0=0 finite request -> swap on first wrap, STOP=1 on the next wrap.
- UPDATE_SETTINGS (REQ=1, REP_1=5) in the same cycle as a wrap while WAIT_BOUNDARY for segment 0 -> SEGMENT unchanged that cycle, SWAP_PENDING stays 1, and the swap to 1 happens at the following wrap.
- RST_N pulsed low during FINITE_LOOP at loop 1 -> all outputs return to reset values immediately (asynchronous). With MOD_SWAPCHAIN_DEBUG_EN, LOOP_CNT=0 and STATE=0.
